// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: the ROM port, the decode valid/ready handshake and the branch redirect.
// master = fetch_sequencer, slave = the surrounding ROM/decode/branch logic.
interface fetch_sequencer_if;
  logic [15:0] rom_addr;
  logic [15:0] rom_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output rom_addr,
    input  rom_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a zero-latency ROM and buffers {instr, pc}
// in a prefetch FIFO drained by decode. Optional HALT-opcode stop enabled by `FETCH_HALT_EN.
module fetch_sequencer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fetch_sequencer_if.master          bus,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     pc_q, pc_d;
  logic            halted_q, halted_d;

  logic        out_valid;
  logic        pop;
  logic        push;
  logic [31:0] head;

  assign out_valid = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    pop  = out_valid & bus.out_ready;
    push = ~bus.redirect_valid & ~halted_q & ((count_q < CntW'(DEPTH)) | pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    halted_d = halted_q;

    if (bus.redirect_valid) begin
      // A same-cycle pop is simply absorbed by the flush.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.redirect_pc;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.rom_instr, pc_q};
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
        pc_d            = pc_q + 16'd1;
`ifdef FETCH_HALT_EN
        if (bus.rom_instr[15:12] == 4'hF) halted_d = 1'b1;
`endif
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end

`ifndef FETCH_HALT_EN
    halted_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_VEC;
      halted_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head[31:16] : 16'h0000;
  assign bus.out_pc    = out_valid ? head[15:0]  : 16'h0000;
  assign fifo_count    = count_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (DEPTH=2); outputs sampled 1ns after each rising edge.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] fifo_count;
  logic       halted;
  logic       halt_rom;
  int         total;
  int         bad;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .DEPTH    (2),
    .RESET_VEC(16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fifo_count(fifo_count),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    unique case (bus.rom_addr)
      16'h0000: bus.rom_instr = 16'h0490;
      16'h0001: bus.rom_instr = 16'h0521;
      16'h0002: bus.rom_instr = 16'h05B3;
      16'h0003: bus.rom_instr = 16'hC4A0;
      16'h0004: bus.rom_instr = halt_rom ? 16'hF000 : 16'h0000;
      default:  bus.rom_instr = 16'h0000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n              = 1'b0;
    bus.out_ready      = ready;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    halt_rom = 1'b0;
    do_reset(1'b1);
    total++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 2'd0 || bus.rom_addr !== 16'h0000 ||
        bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b cnt=%0d addr=%h instr=%h pc=%h halted=%b want 0 0 0000 0000 0000 0",
               bus.out_valid, fifo_count, bus.rom_addr, bus.out_instr, bus.out_pc, halted);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_instr [5];
    exp_instr = '{16'h0490, 16'h0521, 16'h05B3, 16'hC4A0, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(i) || bus.out_instr !== exp_instr[i]) begin
        bad++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h want 1 %h %h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, 16'(i), exp_instr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_instr [4];
    exp_instr = '{16'h0490, 16'h0521, 16'h05B3, 16'hC4A0};
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    total++;
    if (fifo_count !== 2'd2 || bus.rom_addr !== 16'h0002) begin
      bad++;
      $display("FAIL backpressure_full: cnt=%0d addr=%h want 2 0002", fifo_count, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(i) || bus.out_instr !== exp_instr[i]) begin
        bad++;
        $display("FAIL backpressure_drain[%0d]: valid=%b pc=%h instr=%h want 1 %h %h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, 16'(i), exp_instr[i]);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0003;
    step();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 2'd0 || bus.rom_addr !== 16'h0003) begin
      bad++;
      $display("FAIL redirect_flush: valid=%b cnt=%0d addr=%h want 0 0 0003",
               bus.out_valid, fifo_count, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0003 || bus.out_instr !== 16'hC4A0) begin
      bad++;
      $display("FAIL redirect_first: valid=%b pc=%h instr=%h want 1 0003 c4a0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0004 || bus.out_instr !== 16'h0000) begin
      bad++;
      $display("FAIL redirect_next: valid=%b pc=%h instr=%h want 1 0004 0000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_wrap();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFF;
    step();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_gap: valid=%b want 0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'hFFFF || bus.out_instr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_ffff: valid=%b pc=%h instr=%h want 1 ffff 0000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h0490) begin
      bad++;
      $display("FAIL wrap_zero: valid=%b pc=%h instr=%h want 1 0000 0490",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_reset_priority();
    do_reset(1'b0);
    step();
    step();
    total++;
    if (fifo_count !== 2'd2) begin
      bad++;
      $display("FAIL rstprio_fill: cnt=%0d want 2", fifo_count);
    end
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0005;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || fifo_count !== 2'd0 || bus.rom_addr !== 16'h0000) begin
      bad++;
      $display("FAIL rstprio: valid=%b cnt=%0d addr=%h want 0 0 0000",
               bus.out_valid, fifo_count, bus.rom_addr);
    end
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_halt();
    halt_rom = 1'b1;
    do_reset(1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0003;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
`ifdef FETCH_HALT_EN
    total++;
    if (halted !== 1'b1 || bus.rom_addr !== 16'h0005 || fifo_count !== 2'd2) begin
      bad++;
      $display("FAIL halt_stop: halted=%b addr=%h cnt=%0d want 1 0005 2",
               halted, bus.rom_addr, fifo_count);
    end
`else
    total++;
    if (halted !== 1'b0 || bus.rom_addr !== 16'h0005 || fifo_count !== 2'd2) begin
      bad++;
      $display("FAIL halt_off_full: halted=%b addr=%h cnt=%0d want 0 0005 2",
               halted, bus.rom_addr, fifo_count);
    end
`endif
    bus.out_ready = 1'b1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0003 || bus.out_instr !== 16'hC4A0) begin
      bad++;
      $display("FAIL halt_drain0: valid=%b pc=%h instr=%h want 1 0003 c4a0",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0004 || bus.out_instr !== 16'hF000) begin
      bad++;
      $display("FAIL halt_drain1: valid=%b pc=%h instr=%h want 1 0004 f000",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
`ifdef FETCH_HALT_EN
    total++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 16'h0005 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_empty: valid=%b addr=%h halted=%b want 0 0005 1",
               bus.out_valid, bus.rom_addr, halted);
    end
`else
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0005 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_off_cont: valid=%b pc=%h halted=%b want 1 0005 0",
               bus.out_valid, bus.out_pc, halted);
    end
`endif
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0000;
    step();
    bus.redirect_valid = 1'b0;
    total++;
    if (halted !== 1'b0 || bus.rom_addr !== 16'h0000 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_clear: halted=%b addr=%h valid=%b want 0 0000 0",
               halted, bus.rom_addr, bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h0490) begin
      bad++;
      $display("FAIL halt_resume: valid=%b pc=%h instr=%h want 1 0000 0490",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    halt_rom           = 1'b0;
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_priority();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
